seq_booth_multiplier: RTL and testbench

- Iterative radix-4 Booth multiplier producing a full 2*WIDTH-bit product over several cycles.
- Successor to the combinational array multiplier: parametrised width, signed/unsigned operand modes and a valid/ready handshake.
- Sits in the ALU as the multi-cycle MUL/MULH/MULHSU/MULHU engine. It shares the codebase's addition primitives for the partial-product accumulator.

---
 rtl/seq_booth_multiplier.sv | 163 ++++++++++++++++
 tb/tb_seq_booth_multiplier.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-4 Booth multiplier: WIDTH x WIDTH -> 2*WIDTH product over ITER+1 cycles,
// with per-operand signed/unsigned extension, valid/ready handshake and abort.
module seq_booth_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_signed,
  input  logic             b_signed,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r_lo,
  output logic [WIDTH-1:0] r_hi
);
  localparam int ITER = WIDTH / 2 + 1;
  localparam int XW   = WIDTH + 2;
  localparam int HW   = WIDTH + 4;
  localparam int CW   = $clog2(ITER + 1);

  generate
    if ((WIDTH % 2 != 0) || (WIDTH < 4)) begin : g_bad_width
      $error("seq_booth_multiplier: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  // One Booth step on the upper accumulator half; subtraction is invert plus carry-in.
  function automatic logic [HW-1:0] booth_add(input logic [HW-1:0] acc,
                                              input logic [HW-1:0] mcand,
                                              input logic [2:0]    trip);
    logic [HW-1:0] mag;
    logic          neg;
    case (trip)
      3'b001, 3'b010: begin mag = mcand;        neg = 1'b0; end
      3'b011:         begin mag = mcand << 1;   neg = 1'b0; end
      3'b100:         begin mag = mcand << 1;   neg = 1'b1; end
      3'b101, 3'b110: begin mag = mcand;        neg = 1'b1; end
      default:        begin mag = {HW{1'b0}};   neg = 1'b0; end
    endcase
    return acc + (neg ? ~mag : mag) + {{(HW-1){1'b0}}, neg};
  endfunction

  state_e          state_q, state_d;
  logic [HW-1:0]   mcand_q, mcand_d;
  logic [HW-1:0]   acc_hi_q, acc_hi_d;
  logic [XW-1:0]   acc_lo_q, acc_lo_d;
  logic            bm1_q, bm1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fin_q, fin_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [WIDTH-1:0] r_lo_q, r_lo_d;
  logic [WIDTH-1:0] r_hi_q, r_hi_d;
  logic [HW-1:0]   sum_s;
  logic [HW+XW-1:0] shift_s;

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    bm1_d       = bm1_q;
    cnt_d       = cnt_q;
    fin_d       = fin_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    r_lo_d      = r_lo_q;
    r_hi_d      = r_hi_q;
    sum_s       = booth_add(acc_hi_q, mcand_q, {acc_lo_q[1:0], bm1_q});
    // Multiplier bits retire from the bottom of acc_lo while product bits enter from the top.
    shift_s     = {{2{sum_s[HW-1]}}, sum_s, acc_lo_q[XW-1:2]};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d    = a_signed ? {{4{a[WIDTH-1]}}, a} : {4'b0000, a};
          acc_lo_d   = b_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
          acc_hi_d   = {HW{1'b0}};
          bm1_d      = 1'b0;
          cnt_d      = CW'(ITER - 1);
          fin_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          fin_d      = 1'b0;
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end else if (fin_q) begin
          r_lo_d      = acc_lo_q[WIDTH-1:0];
          r_hi_d      = {acc_hi_q[WIDTH-3:0], acc_lo_q[XW-1:WIDTH]};
          out_valid_d = 1'b1;
          fin_d       = 1'b0;
          state_d     = DONE;
        end else begin
          acc_hi_d = shift_s[HW+XW-1:XW];
          acc_lo_d = shift_s[XW-1:0];
          bm1_d    = acc_lo_q[1];
          cnt_d    = cnt_q - CW'(1);
          fin_d    = (cnt_q == CW'(0));
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        fin_d       = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= {HW{1'b0}};
      acc_hi_q    <= {HW{1'b0}};
      acc_lo_q    <= {XW{1'b0}};
      bm1_q       <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      fin_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      r_lo_q      <= {WIDTH{1'b0}};
      r_hi_q      <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      bm1_q       <= bm1_d;
      cnt_q       <= cnt_d;
      fin_q       <= fin_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      r_lo_q      <= r_lo_d;
      r_hi_q      <= r_hi_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r_lo      = r_lo_q;
  assign r_hi      = r_hi_q;
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed and random bench for seq_booth_multiplier at WIDTH = 8, 16 and 32.
module tb_seq_booth_multiplier;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic iv [3];
  logic ordy [3];
  logic abt [3];
  logic asg [3];
  logic bsg [3];
  logic [7:0]  a8, b8, lo8, hi8;
  logic [15:0] a16, b16, lo16, hi16;
  logic [31:0] a32, b32, lo32, hi32;
  logic ir8, ov8, ir16, ov16, ir32, ov32;
  int checks = 0;
  int failures = 0;

  seq_booth_multiplier #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir8), .a(a8), .b(b8),
    .a_signed(asg[0]), .b_signed(bsg[0]), .abort(abt[0]), .out_valid(ov8),
    .out_ready(ordy[0]), .r_lo(lo8), .r_hi(hi8));
  seq_booth_multiplier #(.WIDTH(16)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir16), .a(a16), .b(b16),
    .a_signed(asg[1]), .b_signed(bsg[1]), .abort(abt[1]), .out_valid(ov16),
    .out_ready(ordy[1]), .r_lo(lo16), .r_hi(hi16));
  seq_booth_multiplier #(.WIDTH(32)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir32), .a(a32), .b(b32),
    .a_signed(asg[2]), .b_signed(bsg[2]), .abort(abt[2]), .out_valid(ov32),
    .out_ready(ordy[2]), .r_lo(lo32), .r_hi(hi32));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic ov_of(input int k);
    case (k)
      0: return ov8;
      1: return ov16;
      default: return ov32;
    endcase
  endfunction

  function automatic logic ir_of(input int k);
    case (k)
      0: return ir8;
      1: return ir16;
      default: return ir32;
    endcase
  endfunction

  function automatic logic [63:0] prod_of(input int k);
    case (k)
      0: return {48'd0, hi8, lo8};
      1: return {32'd0, hi16, lo16};
      default: return {hi32, lo32};
    endcase
  endfunction

  // Exact product of the extended operands, truncated to 2*w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] x, input logic [31:0] y,
                                           input logic sx, input logic sy);
    logic [63:0] ex, ey, m;
    ex = 64'd0;
    ey = 64'd0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) begin
        ex[i] = x[i[4:0]];
        ey[i] = y[i[4:0]];
      end else begin
        ex[i] = sx & x[w-1];
        ey[i] = sy & y[w-1];
      end
    end
    m = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return (ex * ey) & m;
  endfunction

  task automatic issue(input int k, input logic [31:0] x, input logic [31:0] y,
                       input logic sx, input logic sy);
    case (k)
      0: begin a8 = x[7:0]; b8 = y[7:0]; end
      1: begin a16 = x[15:0]; b16 = y[15:0]; end
      default: begin a32 = x; b32 = y; end
    endcase
    asg[k] = sx;
    bsg[k] = sy;
    iv[k] = 1'b1;
    tick(1);
    iv[k] = 1'b0;
  endtask

  task automatic wait_res(input int k, input string tag, output logic [63:0] p);
    int n;
    int iter;
    n = 0;
    iter = (k == 0) ? 5 : ((k == 1) ? 9 : 17);
    while (ov_of(k) !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(iter + 1));
    p = prod_of(k);
  endtask

  task automatic consume(input int k, input string tag, input int stall, input logic [63:0] p);
    tick(stall);
    if (stall > 0) chk({tag, "_hold"}, prod_of(k), p);
    ordy[k] = 1'b1;
    tick(1);
    ordy[k] = 1'b0;
    chk({tag, "_idle"}, {62'd0, ir_of(k), ov_of(k)}, 64'd2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    logic [31:0] x, y;
    logic sx, sy;
    int bad;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; abt[k] = 1'b0; asg[k] = 1'b0; bsg[k] = 1'b0;
    end
    a8 = 8'd0; b8 = 8'd0; a16 = 16'd0; b16 = 16'd0; a32 = 32'd0; b32 = 32'd0;
    rst = 1'b1;
    tick(2);
    chk("reset_state", {30'd0, ir16, ov16, hi16, lo16}, 64'h0000_0002_0000_0000);
    rst = 1'b0;
    tick(1);

    // Unsigned max with out_ready already high: consumed right after out_valid rises.
    ordy[1] = 1'b1;
    issue(1, 32'hFFFF, 32'hFFFF, 1'b0, 1'b0);
    chk("busy_after_accept", {63'd0, ir16}, 64'd0);
    wait_res(1, "uu_max", p);
    chk("uu_max", p, 64'hFFFE_0001);
    tick(1);
    chk("uu_auto_idle", {62'd0, ir16, ov16}, 64'd2);
    ordy[1] = 1'b0;

    issue(1, 32'h8000, 32'h8000, 1'b1, 1'b1);
    wait_res(1, "ss_min", p);
    chk("ss_min", p, 64'h4000_0000);
    consume(1, "ss_min", 2, p);

    issue(1, 32'hFFFF, 32'hFFFF, 1'b1, 1'b1);
    wait_res(1, "ss_m1", p);
    chk("ss_m1", p, 64'h0000_0001);
    consume(1, "ss_m1", 0, p);

    issue(1, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0);
    wait_res(1, "su_m1", p);
    chk("su_m1", p, 64'hFFFF_0001);
    consume(1, "su_m1", 1, p);

    issue(1, 32'h0003, 32'hFFFB, 1'b0, 1'b1);
    wait_res(1, "us_3m5", p);
    chk("us_3m5", p, 64'hFFFF_FFF1);
    consume(1, "us_3m5", 0, p);

    // Backpressure window with a competing request that must be ignored.
    issue(1, 32'h0100, 32'h0100, 1'b0, 1'b0);
    wait_res(1, "bp", p);
    chk("bp_prod", p, 64'h0001_0000);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        a16 = 16'h0002; b16 = 16'h0003; asg[1] = 1'b0; bsg[1] = 1'b0; iv[1] = 1'b1;
      end
      tick(1);
      if (prod_of(1) !== 64'h0001_0000 || ir16 !== 1'b0 || ov16 !== 1'b1) bad++;
    end
    chk("bp_window", 64'(bad), 64'd0);
    ordy[1] = 1'b1;
    tick(1);
    ordy[1] = 1'b0;
    chk("bp_release_ready", {62'd0, ir16, ov16}, 64'd2);
    tick(1);
    iv[1] = 1'b0;
    chk("bp_accept2", {63'd0, ir16}, 64'd0);
    wait_res(1, "bp2", p);
    chk("bp_2x3", p, 64'h0000_0006);
    consume(1, "bp2", 0, p);

    // Abort during RUN: back to IDLE, no output, previous product kept.
    issue(1, 32'h00FF, 32'h00FF, 1'b0, 1'b0);
    tick(3);
    abt[1] = 1'b1;
    tick(1);
    abt[1] = 1'b0;
    chk("abort_idle", {62'd0, ir16, ov16}, 64'd2);
    chk("abort_keep", prod_of(1), 64'h0000_0006);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (ov16 !== 1'b0) bad++;
    end
    chk("abort_no_out", 64'(bad), 64'd0);

    // abort together with in_valid in IDLE: operation still accepted.
    abt[1] = 1'b1;
    issue(1, 32'h0005, 32'h0005, 1'b0, 1'b0);
    abt[1] = 1'b0;
    wait_res(1, "abort_iv", p);
    chk("abort_iv", p, 64'h0000_0019);
    consume(1, "abort_iv", 0, p);

    // Asynchronous reset mid-operation.
    issue(1, 32'h1111, 32'h1111, 1'b0, 1'b0);
    tick(5);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async", {30'd0, ir16, ov16, hi16, lo16}, 64'h0000_0002_0000_0000);
    #1;
    rst = 1'b0;
    tick(1);
    issue(1, 32'h1234, 32'h5678, 1'b0, 1'b0);
    wait_res(1, "post_rst", p);
    chk("post_rst", p, 64'h0626_0060);
    consume(1, "post_rst", 0, p);

    // Random regression over the three widths and all sign modes.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 24; i++) begin
        x = $urandom;
        y = $urandom;
        sx = i[0];
        sy = i[1];
        if (i < 4) begin
          x = 32'hFFFF_FFFF;
          y = 32'hFFFF_FFFF;
        end else if (i < 8) begin
          x = 32'h8000_0000 >> (32 - ((k == 0) ? 8 : ((k == 1) ? 16 : 32)));
          y = x;
        end
        issue(k, x, y, sx, sy);
        wait_res(k, "rnd", p);
        chk("rnd_prod", p, ref_prod((k == 0) ? 8 : ((k == 1) ? 16 : 32), x, y, sx, sy));
        consume(k, "rnd", $urandom_range(0, 3), p);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
